// File: rtl/voice_pkg.sv
// -----------------------------------------------------------------------------
// voice_pkg
// Shared types and widths for the voice allocator.
//   voice_state_t : per-voice lifecycle (IDLE / ACTIVE / RELEASE)
//   ctrl_state_t  : event controller FSM state (WAIT / LOOKUP / COMMIT)
//   slot_cmd_t    : command issued to one voice slot in the COMMIT cycle
// Optional feature macro used by the allocator: VOICE_STEAL_EN.
// -----------------------------------------------------------------------------
package voice_pkg;

  localparam int NOTE_W = 7;
  localparam int VEL_W  = 7;
  localparam int AGE_W  = 16;

  typedef enum logic [1:0] {
    V_IDLE    = 2'd0,
    V_ACTIVE  = 2'd1,
    V_RELEASE = 2'd2
  } voice_state_t;

  typedef enum logic [1:0] {
    C_WAIT   = 2'd0,
    C_LOOKUP = 2'd1,
    C_COMMIT = 2'd2
  } ctrl_state_t;

  // CMD_START covers fresh allocation, retrigger and steal alike: the slot
  // reloads note/velocity, goes ACTIVE, clears its age and pulses trig.
  typedef enum logic [1:0] {
    CMD_NONE    = 2'd0,
    CMD_START   = 2'd1,
    CMD_RELEASE = 2'd2
  } slot_cmd_t;

endpackage

// File: rtl/voice_slot.sv
// -----------------------------------------------------------------------------
// voice_slot
// State of one synthesizer voice: lifecycle state, note, velocity, 16-bit
// saturating age and release hold counter.
// Ports:
//   clk, reset_n        : clock, asynchronous active-low reset
//   sample_tick         : one-clk pulse per audio sample
//   cmd, cmd_note,
//   cmd_vel             : command from the controller (valid in COMMIT only)
//   state_o, note_o,
//   vel_o, age_o        : current slot contents
//   trig_o              : one-clk pulse after a START command
// -----------------------------------------------------------------------------
module voice_slot
  import voice_pkg::*;
#(
  parameter int RELEASE_TICKS = 4800
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                sample_tick,
  input  slot_cmd_t           cmd,
  input  logic [NOTE_W-1:0]   cmd_note,
  input  logic [VEL_W-1:0]    cmd_vel,
  output voice_state_t        state_o,
  output logic [NOTE_W-1:0]   note_o,
  output logic [VEL_W-1:0]    vel_o,
  output logic [AGE_W-1:0]    age_o,
  output logic                trig_o
);

  localparam int REL_W_RAW = $clog2(RELEASE_TICKS + 1);
  localparam int REL_W     = (REL_W_RAW < 1) ? 1 : REL_W_RAW;
  localparam logic [REL_W-1:0] REL_LOAD = REL_W'(RELEASE_TICKS);

  voice_state_t        state_q, state_d;
  logic [NOTE_W-1:0]   note_q, note_d;
  logic [VEL_W-1:0]    vel_q, vel_d;
  logic [AGE_W-1:0]    age_q, age_d;
  logic [REL_W-1:0]    rel_q, rel_d;
  logic                trig_q, trig_d;

  always_comb begin
    state_d = state_q;
    note_d  = note_q;
    vel_d   = vel_q;
    age_d   = age_q;
    rel_d   = rel_q;
    trig_d  = 1'b0;

    // Background activity driven by the sample clock.
    if (sample_tick && (age_q != '1)) begin
      age_d = age_q + 1'b1;
    end
    if (sample_tick && (state_q == V_RELEASE)) begin
      // A count of 1 means this tick takes it to zero; note/vel are kept.
      if (rel_q <= REL_W'(1)) begin
        rel_d   = '0;
        state_d = V_IDLE;
      end else begin
        rel_d = rel_q - 1'b1;
      end
    end

    // A controller command overrides the background update on the same edge.
    case (cmd)
      CMD_START: begin
        state_d = V_ACTIVE;
        note_d  = cmd_note;
        vel_d   = cmd_vel;
        age_d   = '0;
        rel_d   = '0;
        trig_d  = 1'b1;
      end
      CMD_RELEASE: begin
        state_d = V_RELEASE;
        rel_d   = REL_LOAD;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= V_IDLE;
      note_q  <= '0;
      vel_q   <= '0;
      age_q   <= '0;
      rel_q   <= '0;
      trig_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      note_q  <= note_d;
      vel_q   <= vel_d;
      age_q   <= age_d;
      rel_q   <= rel_d;
      trig_q  <= trig_d;
    end
  end

  assign state_o = state_q;
  assign note_o  = note_q;
  assign vel_o   = vel_q;
  assign age_o   = age_q;
  assign trig_o  = trig_q;

endmodule

// File: rtl/voice_allocator.sv
// -----------------------------------------------------------------------------
// voice_allocator
// Maps MIDI note-on / note-off events onto NUM_VOICES voice slots.
// Ports:
//   clk, reset_n               : clock, asynchronous active-low reset
//   sample_tick                : one-clk pulse per audio sample
//   ev_valid/ev_ready          : event handshake
//   ev_on, ev_note, ev_vel     : event payload (note-on with vel 0 = note-off)
//   voice_gate/busy/trig       : per-voice held / sounding / retrigger pulse
//   voice_note, voice_vel      : per-voice note and velocity, voice i at [7i+6:7i]
//   ev_dropped                 : one-clk pulse when a note-on finds no voice
//   dbg_state                  : controller FSM state, for observation only
// Optional feature: define VOICE_STEAL_EN to steal the oldest voice when none
// is idle; otherwise such a note-on is dropped.
//
// Handshake: an event transfers on a rising edge where ev_valid and ev_ready
// are both high. ev_ready is high only while the controller is in WAIT, and
// the payload is registered on that edge, so the source may change ev_* freely
// afterwards. The producer may hold ev_valid high; each event takes 3 clk.
// -----------------------------------------------------------------------------
module voice_allocator
  import voice_pkg::*;
#(
  parameter int NUM_VOICES    = 4,
  parameter int RELEASE_TICKS = 4800
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         sample_tick,
  input  logic                         ev_valid,
  output logic                         ev_ready,
  input  logic                         ev_on,
  input  logic [NOTE_W-1:0]            ev_note,
  input  logic [VEL_W-1:0]             ev_vel,
  output logic [NUM_VOICES-1:0]        voice_gate,
  output logic [NUM_VOICES-1:0]        voice_busy,
  output logic [NUM_VOICES-1:0]        voice_trig,
  output logic [NOTE_W*NUM_VOICES-1:0] voice_note,
  output logic [VEL_W*NUM_VOICES-1:0]  voice_vel,
  output logic                         ev_dropped,
  output ctrl_state_t                  dbg_state
);

  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  // Per-slot views
  voice_state_t      slot_state [NUM_VOICES];
  logic [NOTE_W-1:0] slot_note  [NUM_VOICES];
  logic [VEL_W-1:0]  slot_vel   [NUM_VOICES];
  logic [AGE_W-1:0]  slot_age   [NUM_VOICES];
  slot_cmd_t         slot_cmd   [NUM_VOICES];

  // Controller registers
  ctrl_state_t       state_q, state_d;
  logic              ready_q, ready_d;
  logic              ev_on_q, ev_on_d;
  logic [NOTE_W-1:0] ev_note_q, ev_note_d;
  logic [VEL_W-1:0]  ev_vel_q, ev_vel_d;
  slot_cmd_t         lk_cmd_q, lk_cmd_d;
  logic [IDX_W-1:0]  lk_idx_q, lk_idx_d;
  logic              lk_drop_q, lk_drop_d;
  logic              dropped_q, dropped_d;

  // Lookup results (combinational on the registered event)
  logic              busy_hit, act_hit, idle_hit;
  logic [IDX_W-1:0]  busy_idx, act_idx, idle_idx, old_idx;
  logic [AGE_W-1:0]  old_age;
  logic              is_note_on;

  assign is_note_on = ev_on_q && (ev_vel_q != '0);

  always_comb begin
    busy_hit = 1'b0;
    busy_idx = '0;
    act_hit  = 1'b0;
    act_idx  = '0;
    idle_hit = 1'b0;
    idle_idx = '0;
    // Walk downwards so the last hit written is the lowest index.
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if ((slot_state[i] != V_IDLE) && (slot_note[i] == ev_note_q)) begin
        busy_hit = 1'b1;
        busy_idx = IDX_W'(i);
      end
      if ((slot_state[i] == V_ACTIVE) && (slot_note[i] == ev_note_q)) begin
        act_hit = 1'b1;
        act_idx = IDX_W'(i);
      end
      if (slot_state[i] == V_IDLE) begin
        idle_hit = 1'b1;
        idle_idx = IDX_W'(i);
      end
    end
  end

  // Oldest voice: strict greater-than keeps the lowest index on ties.
  always_comb begin
    old_idx = '0;
    old_age = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (slot_age[i] > old_age) begin
        old_age = slot_age[i];
        old_idx = IDX_W'(i);
      end
    end
  end

  // Controller FSM: WAIT -> LOOKUP -> COMMIT -> WAIT
  always_comb begin
    state_d   = state_q;
    ev_on_d   = ev_on_q;
    ev_note_d = ev_note_q;
    ev_vel_d  = ev_vel_q;
    lk_cmd_d  = lk_cmd_q;
    lk_idx_d  = lk_idx_q;
    lk_drop_d = lk_drop_q;
    dropped_d = 1'b0;

    case (state_q)
      C_WAIT: begin
        if (ev_valid && ready_q) begin
          ev_on_d   = ev_on;
          ev_note_d = ev_note;
          ev_vel_d  = ev_vel;
          state_d   = C_LOOKUP;
        end
      end
      C_LOOKUP: begin
        lk_cmd_d  = CMD_NONE;
        lk_idx_d  = '0;
        lk_drop_d = 1'b0;
        if (is_note_on) begin
          if (busy_hit) begin
            lk_cmd_d = CMD_START;
            lk_idx_d = busy_idx;
          end else if (idle_hit) begin
            lk_cmd_d = CMD_START;
            lk_idx_d = idle_idx;
          end else begin
`ifdef VOICE_STEAL_EN
            lk_cmd_d = CMD_START;
            lk_idx_d = old_idx;
`else
            lk_drop_d = 1'b1;
`endif
          end
        end else if (act_hit) begin
          lk_cmd_d = CMD_RELEASE;
          lk_idx_d = act_idx;
        end
        state_d = C_COMMIT;
      end
      C_COMMIT: begin
        dropped_d = lk_drop_q;
        state_d   = C_WAIT;
      end
      default: state_d = C_WAIT;
    endcase

    // Registered so ready stays low throughout reset and rises on the first
    // edge after it.
    ready_d = (state_d == C_WAIT);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= C_WAIT;
      ready_q   <= 1'b0;
      ev_on_q   <= 1'b0;
      ev_note_q <= '0;
      ev_vel_q  <= '0;
      lk_cmd_q  <= CMD_NONE;
      lk_idx_q  <= '0;
      lk_drop_q <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ready_q   <= ready_d;
      ev_on_q   <= ev_on_d;
      ev_note_q <= ev_note_d;
      ev_vel_q  <= ev_vel_d;
      lk_cmd_q  <= lk_cmd_d;
      lk_idx_q  <= lk_idx_d;
      lk_drop_q <= lk_drop_d;
      dropped_q <= dropped_d;
    end
  end

  assign ev_ready   = ready_q;
  assign ev_dropped = dropped_q;
  assign dbg_state  = state_q;

  // Voice slots
  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_slot
    logic slot_trig;

    assign slot_cmd[g] = ((state_q == C_COMMIT) && (lk_idx_q == IDX_W'(g)))
                         ? lk_cmd_q : CMD_NONE;

    voice_slot #(
      .RELEASE_TICKS (RELEASE_TICKS)
    ) u_slot (
      .clk         (clk),
      .reset_n     (reset_n),
      .sample_tick (sample_tick),
      .cmd         (slot_cmd[g]),
      .cmd_note    (ev_note_q),
      .cmd_vel     (ev_vel_q),
      .state_o     (slot_state[g]),
      .note_o      (slot_note[g]),
      .vel_o       (slot_vel[g]),
      .age_o       (slot_age[g]),
      .trig_o      (slot_trig)
    );

    assign voice_gate[g]                 = (slot_state[g] == V_ACTIVE);
    assign voice_busy[g]                 = (slot_state[g] != V_IDLE);
    assign voice_trig[g]                 = slot_trig;
    assign voice_note[NOTE_W*g +: NOTE_W] = slot_note[g];
    assign voice_vel[VEL_W*g +: VEL_W]    = slot_vel[g];
  end

endmodule

// File: tb/tb_voice_allocator.sv
// -----------------------------------------------------------------------------
// tb_voice_allocator
// Directed bench for voice_allocator (NUM_VOICES=4, RELEASE_TICKS=8).
// Builds with or without VOICE_STEAL_EN; expectations follow the macro.
// -----------------------------------------------------------------------------
module tb_voice_allocator;
  import voice_pkg::*;

  localparam int NV = 4;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic              sample_tick = 1'b0;
  logic              ev_valid = 1'b0;
  logic              ev_ready;
  logic              ev_on = 1'b0;
  logic [6:0]        ev_note = '0;
  logic [6:0]        ev_vel = '0;
  logic [NV-1:0]     voice_gate, voice_busy, voice_trig;
  logic [7*NV-1:0]   voice_note, voice_vel;
  logic              ev_dropped;
  ctrl_state_t       dbg_state;

  voice_allocator #(
    .NUM_VOICES    (NV),
    .RELEASE_TICKS (8)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .sample_tick (sample_tick),
    .ev_valid    (ev_valid),
    .ev_ready    (ev_ready),
    .ev_on       (ev_on),
    .ev_note     (ev_note),
    .ev_vel      (ev_vel),
    .voice_gate  (voice_gate),
    .voice_busy  (voice_busy),
    .voice_trig  (voice_trig),
    .voice_note  (voice_note),
    .voice_vel   (voice_vel),
    .ev_dropped  (ev_dropped),
    .dbg_state   (dbg_state)
  );

  // ---------------------------------------------------------------- scoreboard
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------- drivers
  // All driving and sampling happens 1 ns after a rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!ev_ready && n < 10) begin
      step();
      n++;
    end
    check({tag, "_ready_timeout"}, 64'(ev_ready), 64'd1);
  endtask

  // Issues one event; returns 1 ns after the COMMIT edge.
  task automatic do_event(input string tag, input logic on, input logic [6:0] note,
                          input logic [6:0] vel);
    wait_ready(tag);
    ev_valid = 1'b1;
    ev_on    = on;
    ev_note  = note;
    ev_vel   = vel;
    step();            // accept edge
    ev_valid = 1'b0;
    step();            // LOOKUP -> COMMIT
    step();            // COMMIT edge: outputs update
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      sample_tick = 1'b1;
      step();
      sample_tick = 1'b0;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gate"},  64'(voice_gate), 64'd0);
    check({tag, "_busy"},  64'(voice_busy), 64'd0);
    check({tag, "_trig"},  64'(voice_trig), 64'd0);
    check({tag, "_note"},  64'(voice_note), 64'd0);
    check({tag, "_vel"},   64'(voice_vel),  64'd0);
    check({tag, "_drop"},  64'(ev_dropped), 64'd0);
    check({tag, "_ready"}, 64'(ev_ready),   64'd0);
  endtask

  // ---------------------------------------------------------------- stimulus
  logic [7*NV-1:0] exp_note, exp_vel, snap_note, snap_vel;
  logic [NV-1:0]   snap_gate, snap_busy;

  initial begin
    // Reset state
    repeat (3) step();
    check_all_zero("rst");
    check("rst_state", 64'(dbg_state), 64'(C_WAIT));
    reset_n = 1'b1;
    step();
    check("rst_ready_after", 64'(ev_ready), 64'd1);

    // First note-on: latency 2 clk after accept
    ev_valid = 1'b1; ev_on = 1'b1; ev_note = 7'd60; ev_vel = 7'd100;
    step();
    ev_valid = 1'b0;
    check("on60_lookup_state", 64'(dbg_state), 64'(C_LOOKUP));
    check("on60_lookup_gate", 64'(voice_gate), 64'd0);
    check("on60_lookup_ready", 64'(ev_ready), 64'd0);
    step();
    check("on60_commit_gate", 64'(voice_gate), 64'd0);
    step();
    check("on60_gate", 64'(voice_gate), 64'b0001);
    check("on60_note", 64'(voice_note[6:0]), 64'd60);
    check("on60_vel",  64'(voice_vel[6:0]),  64'd100);
    check("on60_trig", 64'(voice_trig), 64'b0001);
    step();
    check("on60_trig_gone", 64'(voice_trig), 64'd0);

    // Fill voices, release voice1
    do_event("on62", 1'b1, 7'd62, 7'd90);
    check("on62_trig", 64'(voice_trig), 64'b0010);
    do_event("on64", 1'b1, 7'd64, 7'd80);
    do_event("on65", 1'b1, 7'd65, 7'd70);
    exp_note = {7'd65, 7'd64, 7'd62, 7'd60};
    check("fill_gate", 64'(voice_gate), 64'b1111);
    check("fill_note", 64'(voice_note), 64'(exp_note));
    do_event("off62", 1'b0, 7'd62, 7'd0);
    check("off62_gate", 64'(voice_gate), 64'b1101);
    check("off62_busy", 64'(voice_busy), 64'b1111);
    check("off62_trig", 64'(voice_trig), 64'd0);
    ticks(7);
    check("rel_7_busy", 64'(voice_busy), 64'b1111);
    ticks(1);
    check("rel_8_busy", 64'(voice_busy), 64'b1101);
    check("rel_8_note_kept", 64'(voice_note[13:7]), 64'd62);

    // Note-on with velocity 0 acts as note-off
    do_event("on60v0", 1'b1, 7'd60, 7'd0);
    check("on60v0_gate", 64'(voice_gate), 64'b1100);
    check("on60v0_busy", 64'(voice_busy), 64'b1101);
    check("on60v0_trig", 64'(voice_trig), 64'd0);
    snap_gate = voice_gate; snap_busy = voice_busy;
    snap_note = voice_note; snap_vel = voice_vel;
    do_event("off61", 1'b0, 7'd61, 7'd0);
    check("off61_gate", 64'(voice_gate), 64'(snap_gate));
    check("off61_busy", 64'(voice_busy), 64'(snap_busy));
    check("off61_note", 64'(voice_note), 64'(snap_note));
    check("off61_vel",  64'(voice_vel),  64'(snap_vel));
    check("off61_trig", 64'(voice_trig), 64'd0);

    // Fresh start, then all four voices held with voice2 oldest
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    do_event("s40", 1'b1, 7'd40, 7'd100);
    do_event("s41", 1'b1, 7'd41, 7'd100);
    do_event("s42", 1'b1, 7'd42, 7'd100);
    ticks(2);
    do_event("rt40", 1'b1, 7'd40, 7'd50);
    check("rt40_trig", 64'(voice_trig), 64'b0001);
    check("rt40_vel",  64'(voice_vel[6:0]), 64'd50);
    check("rt40_gate", 64'(voice_gate), 64'b0111);
    do_event("rt41", 1'b1, 7'd41, 7'd60);
    do_event("s43", 1'b1, 7'd43, 7'd90);
    check("s43_trig", 64'(voice_trig), 64'b1000);
    ticks(1);
    do_event("on70", 1'b1, 7'd70, 7'd120);
`ifdef VOICE_STEAL_EN
    exp_note = {7'd43, 7'd70, 7'd41, 7'd40};
    exp_vel  = {7'd90, 7'd120, 7'd60, 7'd50};
    check("steal_trig", 64'(voice_trig), 64'b0100);
    check("steal_drop", 64'(ev_dropped), 64'd0);
`else
    exp_note = {7'd43, 7'd42, 7'd41, 7'd40};
    exp_vel  = {7'd90, 7'd100, 7'd60, 7'd50};
    check("drop_trig", 64'(voice_trig), 64'd0);
    check("drop_pulse", 64'(ev_dropped), 64'd1);
`endif
    check("on70_gate", 64'(voice_gate), 64'b1111);
    check("on70_note", 64'(voice_note), 64'(exp_note));
    check("on70_vel",  64'(voice_vel),  64'(exp_vel));
    step();
    check("on70_drop_gone", 64'(ev_dropped), 64'd0);
    check("on70_trig_gone", 64'(voice_trig), 64'd0);

    // ev_valid held high: ready pattern 1,0,0 (ignored note-offs)
    ev_valid = 1'b1; ev_on = 1'b0; ev_note = 7'd99; ev_vel = 7'd0;
    for (int i = 0; i < 9; i++) begin
      check($sformatf("ready_pat%0d", i), 64'(ev_ready), (i % 3 == 0) ? 64'd1 : 64'd0);
      step();
    end
    ev_valid = 1'b0;
    check("ready_pat_gate", 64'(voice_gate), 64'b1111);

    // Reset asserted during LOOKUP discards the event
    wait_ready("mid");
    ev_valid = 1'b1; ev_on = 1'b1; ev_note = 7'd80; ev_vel = 7'd127;
    step();
    ev_valid = 1'b0;
    check("mid_in_lookup", 64'(dbg_state), 64'(C_LOOKUP));
    reset_n = 1'b0;
    #1;
    check_all_zero("mid_rst");
    check("mid_rst_state", 64'(dbg_state), 64'(C_WAIT));
    step();
    reset_n = 1'b1;
    step();
    check("mid_ready", 64'(ev_ready), 64'd1);
    repeat (3) step();
    check("mid_after_gate", 64'(voice_gate), 64'd0);
    check("mid_after_trig", 64'(voice_trig), 64'd0);
    check("mid_after_note", 64'(voice_note), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/voice_allocator.md
VOICE_ALLOCATOR -- requirements
Module: voice_allocator

Interface
REQ-001 The block SHALL have parameter NUM_VOICES, default 4, giving the number of voice slots (one per mixer sample input).
REQ-002 The block SHALL have parameter RELEASE_TICKS, default 4800, giving the release hold time in sample ticks.
REQ-003 The block SHALL have clk  input  1  sole clock; all logic is on its rising edge.
REQ-004 The block SHALL have reset_n  input  1  asynchronous active-low reset.
REQ-005 The block SHALL have sample_tick  input  1  one-clk pulse per audio sample, already in the clk domain.
REQ-006 The block SHALL have ev_valid  input  1  MIDI note event present.
REQ-007 The block SHALL have ev_ready  output  1  event accepted when ev_valid and ev_ready are both high on a rising edge.
REQ-008 The block SHALL have ev_on  input  1  1 = note-on, 0 = note-off.
REQ-009 The block SHALL have ev_note  input  7  MIDI note number.
REQ-010 The block SHALL have ev_vel  input  7  MIDI velocity.
REQ-011 The block SHALL have voice_gate, voice_busy and voice_trig, each output NUM_VOICES: held, sounding, and one-clk retrigger pulse per voice.
REQ-012 The block SHALL have voice_note and voice_vel, each output 7*NUM_VOICES: per-voice note and velocity, voice i at bits [7i+6:7i].
REQ-013 The block SHALL have ev_dropped  output  1  one-clk pulse when a note-on finds no voice.

Function
REQ-014 Each voice SHALL be IDLE, ACTIVE or RELEASE; gate = ACTIVE; busy = ACTIVE or RELEASE.
REQ-015 The controller FSM SHALL be WAIT -> LOOKUP -> COMMIT -> WAIT, one clk per state; ev_ready SHALL be high only in WAIT; ev_* SHALL be registered on accept.
REQ-016 LOOKUP SHALL compute the lowest-index busy voice matching the note, the lowest-index IDLE voice, and the oldest voice (max age, tie -> lowest index).
REQ-017 Outputs SHALL change on the COMMIT edge, i.e. 2 clk after the accept edge; next accept is possible 3 clk after the previous one.
REQ-018 A note-on with ev_vel = 0 SHALL be treated as a note-off.
REQ-019 A note-on matching a busy voice SHALL retrigger that voice: ACTIVE, new velocity, age 0, voice_trig pulse.
REQ-020 Otherwise, a note-on SHALL take the lowest IDLE voice: note and velocity loaded, ACTIVE, age 0, voice_trig pulse.
REQ-021 If no voice is IDLE, behaviour SHALL follow REQ-031/REQ-032.
REQ-022 A note-off matching an ACTIVE voice SHALL move it to RELEASE with its release counter loaded to RELEASE_TICKS.
REQ-023 A note-off matching no ACTIVE voice SHALL be ignored with no output change.
REQ-024 Each voice SHALL have a 16-bit age counter that increments on sample_tick and saturates at 0xFFFF.
REQ-025 In RELEASE, the release counter SHALL decrement on sample_tick; on reaching 0 the voice SHALL go IDLE, keeping its note and velocity.
REQ-026 If a COMMIT and a sample_tick or release expiry hit the same voice on the same edge, the COMMIT SHALL win: age 0, state per event.

Reset
REQ-027 While reset_n is low, all voices SHALL be IDLE and the FSM in WAIT.
REQ-028 Reset SHALL clear notes, velocities, ages and counters to 0, and drive voice_trig and ev_dropped to 0.
REQ-029 ev_ready SHALL be 0 during reset and 1 on the first clk edge after release.
REQ-030 A reset mid-event SHALL discard the in-flight event.

Configuration
REQ-031 With VOICE_STEAL_EN defined, a note-on with no IDLE voice SHALL steal the oldest voice: reload it, ACTIVE, age 0, voice_trig pulse, ev_dropped = 0.
REQ-032 Without VOICE_STEAL_EN, that note-on SHALL be discarded with an ev_dropped pulse in COMMIT and no voice change.

Structure
REQ-033 Package voice_pkg SHALL hold voice_state_t (IDLE/ACTIVE/RELEASE), the controller state enum, NOTE_W = 7, VEL_W = 7 and AGE_W = 16.
REQ-034 One sub-module, voice_slot, SHALL hold per-voice state, note, velocity, age and release counter, instantiated NUM_VOICES times.

Verification
REQ-035 After reset, note-on 60/100 -> 2 clk after accept: voice0 gate=1, note=60, vel=100, one trig pulse.
REQ-036 Note-on 60, 62, 64, 65 then note-off 62 -> voice1 RELEASE, gate=0, busy=1; with RELEASE_TICKS=8, IDLE exactly 8 sample_ticks later.
REQ-037 All 4 voices held with voice2 oldest, then note-on 70 -> with VOICE_STEAL_EN voice2 note=70 with trig; without it, ev_dropped pulse and no change.
REQ-038 Note-on 60 vel 0 while voice0 holds 60 -> voice0 RELEASE; note-off 61 -> no output change.
REQ-039 ev_valid held high continuously -> ev_ready pattern 1,0,0 repeating.
REQ-040 Assert reset_n low during LOOKUP -> all outputs 0 and the event never applied.
